cbus_rr_arbiter: RTL and testbench
==================================

# cbus_rr_arbiter

Parametrised N-to-1 arbiter for the cached bus (cbus_req_t / cbus_resp_t). It sits between the CPU-side cbus masters (icache, dcache, uncached path) and the single cbus port toward the AXI bridge.
- Selects fixed-priority or round-robin at elaboration time.
- When idle, grants and forwards in the same cycle as the request, with no added latency.
- Holds the grant for the whole burst until `oresp.last`.
- Exposes grant status for debug and performance counters.

## Interface
Parameters:
- NUM_INPUTS, default 2: number of masters; legal range 1..16.
- ROUND_ROBIN, default 1: 1 = rotating priority, 0 = fixed priority (lowest index wins).
- IDX_W, default max(1, $clog2(NUM_INPUTS)): local, width of index signals.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- ireqs  in  cbus_req_t[NUM_INPUTS]  master requests.
- iresps  out  cbus_resp_t[NUM_INPUTS]  per-master responses.
- oreq  out  cbus_req_t  request to the downstream slave.
- oresp  in  cbus_resp_t  downstream response.
- grant_valid  out  1  a transaction is being forwarded this cycle.
- grant_index  out  IDX_W  index of the forwarded master; 0 when grant_valid = 0.

## Operation
- Registered state:
  - busy (1): 0 = IDLE, 1 = BUSY.
  - index (IDX_W): locked grantee.
  - rr_ptr (IDX_W): highest-priority index for the next arbitration.
- Candidate selection (combinational):
  - Fixed mode: lowest i with `ireqs[i].valid`.
  - RR mode: first valid i scanning rr_ptr, rr_ptr+1, … modulo NUM_INPUTS.
  - `any_valid` = OR of all valids.
- Current grantee: `cur` = BUSY ? index : candidate.
- Forwarding is active when BUSY, or when IDLE with any_valid. While active:
  - `oreq` = ireqs[cur].
  - `iresps[cur]` = oresp; all other iresps = '0.
  - grant_valid = 1; grant_index = cur.
- When forwarding is not active: oreq = '0, iresps = '0, grant_valid = 0, grant_index = 0.
- Transitions:
  - IDLE, any_valid, !oresp.last: go to BUSY; index <= cur.
  - IDLE, any_valid, oresp.last (single-beat completion in the grant cycle): stay IDLE; the transaction is complete.
  - BUSY, oresp.last: go to IDLE.
  - BUSY, !oresp.last: stay BUSY; the grant is held regardless of other requests.
- Pointer update, RR mode only: on every completion (forwarding active and oresp.last), rr_ptr <= (cur == NUM_INPUTS-1) ? 0 : cur+1. Fixed mode holds rr_ptr at 0.
- A grantee dropping valid while BUSY is a protocol violation. The arbiter keeps the grant until oresp.last and still forwards ireqs[index], so the invalid request appears on oreq.
- NUM_INPUTS = 1: the block degenerates to a pass-through, with busy tracking for the grant outputs only.

## Timing
- Zero-cycle issue: oreq reflects the winning request combinationally in the first request cycle.
- oresp reaches the grantee in the same cycle it arrives.
- Re-arbitration:
  - The cycle after the last beat is IDLE.
  - A pending request is granted in that cycle, so there are no bubbles between back-to-back transactions.
  - Rotation takes effect at the same time.
- No combinational path from oresp to oreq, other than through the selection when IDLE.
- Reset (resetn = 0 at a clk edge): busy = 0, index = 0, rr_ptr = 0.
- While resetn is low, all outputs are forced to '0, overriding forwarding.
- Reset asserted mid-burst abandons the transaction. After reset, arbitration restarts from master 0.
- Simultaneous requests in IDLE: exactly one winner per the mode rules. Losers see iresps = '0 and must hold their requests.

## Test plan
- N=3, RR, masters 0 and 2 request 4-beat bursts together at t0:
  - oreq = req0 at t0, with no latency.
  - master 0 gets 4 beats, last at t3.
  - master 2 is forwarded at t4; master 0 re-requesting at t4 waits.
- N=3, RR, all three request continuously with 1-beat transactions that are ready and last in the same cycle: grant_index sequence is 0,1,2,0,1,2 with busy staying 0.
- N=3, fixed mode, same stimulus as the previous scenario: grant_index is always 0; masters 1 and 2 are starved until master 0 drops valid, then master 1 is granted.
- Burst lock, N=2: master 1 holds an 8-beat burst while master 0 raises valid at beat 3. Master 0 sees iresps = '0 until after last; grant_index stays 1 for 8 cycles.
- resetn pulled low at beat 2 of a 4-beat burst:
  - outputs are 0 during reset.
  - after release, busy = 0 and rr_ptr = 0.
  - the pending master 1 request is granted immediately.
- N=1 pass-through: oreq equals ireqs[0] on every valid cycle; grant_valid tracks activity through a 2-beat burst.

Source files
------------

// File: rtl/cbus_rr_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle around the cbus arbiter: N upstream request/response pairs, one
// downstream pair, and the debug grant status.
interface cbus_rr_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [3:0]  len;
    logic [3:0]  strobe;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

  cbus_req_t              ireqs  [NUM_INPUTS];
  cbus_resp_t             iresps [NUM_INPUTS];
  cbus_req_t              oreq;
  cbus_resp_t             oresp;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_index;

  // slave: the arbiter's view; master: the masters plus downstream slave seen from outside
  modport slave  (input ireqs, oresp, output iresps, oreq, grant_valid, grant_index);
  modport master (output ireqs, oresp, input iresps, oreq, grant_valid, grant_index);
endinterface

// File: rtl/cbus_rr_arbiter.sv
`timescale 1ns/1ps
// N-to-1 cbus arbiter: grants in the request cycle when idle, locks the grantee
// until oresp.last, and rotates priority after each completion in RR mode.
module cbus_rr_arbiter #(
  parameter int NUM_INPUTS  = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  cbus_rr_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} stateT;

  stateT            r_state;
  stateT            w_stateNext;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] w_indexNext;
  logic [IDX_W-1:0] r_rrPtr;
  logic [IDX_W-1:0] w_rrPtrNext;
  logic [IDX_W-1:0] w_candidate;
  logic [IDX_W-1:0] w_cur;
  logic             w_anyValid;
  logic             w_active;
  logic             w_complete;

  // Scan starts at rr_ptr in RR mode and at 0 in fixed mode; first valid wins.
  always_comb begin
    logic found;
    int   pos;
    found       = 1'b0;
    pos         = 0;
    w_candidate = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      pos = (ROUND_ROBIN ? int'(r_rrPtr) : 0) + k;
      if (pos >= NUM_INPUTS) pos = pos - NUM_INPUTS;
      if (!found && bus.ireqs[IDX_W'(pos)].valid) begin
        found       = 1'b1;
        w_candidate = IDX_W'(pos);
      end
    end
    w_anyValid = found;
  end

  assign w_cur      = (r_state == BUSY) ? r_index : w_candidate;
  assign w_active   = (r_state == BUSY) || w_anyValid;
  assign w_complete = w_active && bus.oresp.last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_index <= '0;
      r_rrPtr <= '0;
    end else begin
      r_state <= w_stateNext;
      r_index <= w_indexNext;
      r_rrPtr <= w_rrPtrNext;
    end
  end

  // Once locked, the grantee is forwarded even if it drops valid, until the last beat.
  always_comb begin
    w_stateNext     = r_state;
    w_indexNext     = r_index;
    w_rrPtrNext     = r_rrPtr;
    bus.oreq        = '0;
    bus.grant_valid = 1'b0;
    bus.grant_index = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      bus.iresps[i] = '0;
    end

    case (r_state)
      IDLE: begin
        if (w_anyValid && !bus.oresp.last) begin
          w_stateNext = BUSY;
          w_indexNext = w_cur;
        end
      end
      BUSY: begin
        if (bus.oresp.last) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase

    if (ROUND_ROBIN && w_complete) begin
      w_rrPtrNext = (int'(w_cur) == NUM_INPUTS - 1) ? '0 : w_cur + 1'b1;
    end

    if (resetn && w_active) begin
      bus.oreq          = bus.ireqs[w_cur];
      bus.iresps[w_cur] = bus.oresp;
      bus.grant_valid   = 1'b1;
      bus.grant_index   = w_cur;
    end
  end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
`timescale 1ns/1ps
// Bench for cbus_rr_arbiter: randomized RR traffic against an owner/last-served
// scoreboard, then directed fixed-priority and single-input pass-through cases.
module tb_cbus_rr_arbiter;
  localparam int N = 3;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [3:0]  len;
    logic [3:0]  strobe;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reqT;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } respT;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cbus_rr_arbiter_if #(.NUM_INPUTS(N)) rrBus ();
  cbus_rr_arbiter_if #(.NUM_INPUTS(N)) fixBus ();
  cbus_rr_arbiter_if #(.NUM_INPUTS(1)) oneBus ();

  cbus_rr_arbiter #(.NUM_INPUTS(N), .ROUND_ROBIN(1'b1)) dutRr  (.clk(clk), .resetn(resetn), .bus(rrBus));
  cbus_rr_arbiter #(.NUM_INPUTS(N), .ROUND_ROBIN(1'b0)) dutFix (.clk(clk), .resetn(resetn), .bus(fixBus));
  cbus_rr_arbiter #(.NUM_INPUTS(1), .ROUND_ROBIN(1'b1)) dutOne (.clk(clk), .resetn(resetn), .bus(oneBus));

  int   checkCount = 0;
  int   errorCount = 0;
  bit   phaseRandom = 1'b0;
  int   issued = 0;
  int   completed = 0;

  reqT  pendReq   [N];
  bit   active    [N];
  int   doneCount [N];
  int   seenDone  [N];
  reqT  expQ      [N][$];
  respT slaveResp;
  int   slaveBeats;
  int   owner;
  int   lastServed;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowestIndex(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  // Masters: each keeps one transaction outstanding and holds it until its last beat comes back.
  initial begin : masterDriver
    for (int i = 0; i < N; i++) begin
      rrBus.ireqs[i] = '0;
      active[i]      = 1'b0;
      seenDone[i]    = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (seenDone[i] != doneCount[i]) begin
          seenDone[i] = doneCount[i];
          active[i]   = 1'b0;
        end
        if (!active[i] && phaseRandom && $urandom_range(0, 3) != 0) begin
          pendReq[i].valid   = 1'b1;
          pendReq[i].isWrite = 1'($urandom_range(0, 1));
          pendReq[i].len     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
          pendReq[i].strobe  = 4'($urandom);
          pendReq[i].addr    = $urandom;
          pendReq[i].wdata   = $urandom;
          active[i]          = 1'b1;
          expQ[i].push_back(pendReq[i]);
          issued++;
        end
        rrBus.ireqs[i] = active[i] ? pendReq[i] : '0;
      end
    end
  end

  // Downstream slave: random wait states, last on beat len+1 of the forwarded request.
  initial begin : slaveDriver
    slaveResp   = '0;
    slaveBeats  = 0;
    rrBus.oresp = '0;
    forever begin
      @(posedge clk);
      #2;
      slaveResp = '0;
      if (resetn && rrBus.grant_valid) begin
        slaveResp.ready = ($urandom_range(0, 3) != 0);
        slaveResp.last  = slaveResp.ready && (slaveBeats == int'(rrBus.oreq.len));
        slaveResp.rdata = $urandom;
      end
      rrBus.oresp = slaveResp;
      @(negedge clk);
      if (!resetn) slaveBeats = 0;
      else if (slaveResp.ready) slaveBeats = slaveResp.last ? 0 : slaveBeats + 1;
    end
  end

  // Scoreboard: an owner holds the bus until its last beat; a free bus goes to the
  // first requester after the one served last.
  initial begin : monitor
    respT expResp;
    int   m;
    owner      = -1;
    lastServed = N - 1;
    for (int i = 0; i < N; i++) doneCount[i] = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        checkOutput("resetGrantValid", rrBus.grant_valid, 0);
        checkOutput("resetGrantIndex", rrBus.grant_index, 0);
        checkOutput("resetOreq", rrBus.oreq, 0);
        for (int i = 0; i < N; i++) checkOutput($sformatf("resetIresps%0d", i), rrBus.iresps[i], 0);
        owner      = -1;
        lastServed = N - 1;
      end else begin
        if (owner < 0) begin
          for (int k = 1; k <= N; k++) begin
            m = (lastServed + k) % N;
            if (owner < 0 && active[m]) owner = m;
          end
        end
        if (owner < 0) begin
          checkOutput("idleGrantValid", rrBus.grant_valid, 0);
          checkOutput("idleGrantIndex", rrBus.grant_index, 0);
          checkOutput("idleOreq", rrBus.oreq, 0);
          for (int i = 0; i < N; i++) checkOutput($sformatf("idleIresps%0d", i), rrBus.iresps[i], 0);
        end else begin
          checkOutput("grantValid", rrBus.grant_valid, 1);
          checkOutput("grantIndex", rrBus.grant_index, owner);
          checkOutput("scoreboardEntry", expQ[owner].size(), 1);
          if (expQ[owner].size() != 0) checkOutput("oreq", rrBus.oreq, expQ[owner][0]);
          for (int i = 0; i < N; i++) begin
            expResp = (i == owner) ? slaveResp : '0;
            checkOutput($sformatf("iresps%0d", i), rrBus.iresps[i], expResp);
          end
          if (slaveResp.last) begin
            if (expQ[owner].size() != 0) void'(expQ[owner].pop_front());
            completed++;
            lastServed = owner;
            owner      = -1;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (rrBus.iresps[i].ready && rrBus.iresps[i].last) doneCount[i]++;
        end
      end
    end
  end

  logic [N-1:0] fixMasks [8] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b110, 3'b100, 3'b000};
  bit           oneValid [6] = '{1, 1, 0, 0, 1, 0};
  bit           oneReady [6] = '{1, 0, 1, 0, 1, 0};
  bit           oneLast  [6] = '{0, 0, 1, 0, 1, 0};
  bit           oneGrant [6] = '{1, 1, 1, 0, 1, 0};

  initial begin : mainSequence
    reqT  fixReq [N];
    reqT  oneReq;
    respT resp;
    respT expResp;
    int   win;
    int   waitCycles;
    bit   pending;

    resetn        = 1'b0;
    fixBus.oresp  = '0;
    oneBus.oresp  = '0;
    oneBus.ireqs[0] = '0;
    for (int i = 0; i < N; i++) fixBus.ireqs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn      = 1'b1;
    phaseRandom = 1'b1;

    // Two mid-burst resets during random traffic.
    for (int r = 0; r < 2; r++) begin
      repeat (700) @(posedge clk);
      waitCycles = 0;
      do begin
        @(posedge clk);
        #3;
        waitCycles++;
      end while (!(rrBus.grant_valid && slaveBeats >= 1) && waitCycles < 200);
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
    end
    repeat (500) @(posedge clk);

    phaseRandom = 1'b0;
    waitCycles  = 0;
    do begin
      @(posedge clk);
      #3;
      waitCycles++;
      pending = 1'b0;
      for (int i = 0; i < N; i++) if (active[i] || expQ[i].size() != 0) pending = 1'b1;
    end while (pending && waitCycles < 1000);
    checkOutput("drainTimeout", pending, 0);
    checkOutput("drainCompleted", completed, issued);

    // Fixed priority: lowest requesting index always wins single-beat transactions.
    for (int i = 0; i < N; i++) begin
      fixReq[i]         = '0;
      fixReq[i].valid   = 1'b1;
      fixReq[i].len     = 4'd0;
      fixReq[i].addr    = 32'h1000 + 32'(i) * 32'h100;
      fixReq[i].wdata   = 32'hA5A5_0000 + 32'(i);
    end
    resp       = '0;
    resp.ready = 1'b1;
    resp.last  = 1'b1;
    resp.rdata = 32'hC0FF_EE00;
    for (int c = 0; c < 8; c++) begin
      applyStimulus();
      for (int i = 0; i < N; i++) fixBus.ireqs[i] = fixMasks[c][i] ? fixReq[i] : '0;
      fixBus.oresp = (fixMasks[c] != '0) ? resp : '0;
      @(negedge clk);
      win = lowestIndex(fixMasks[c]);
      checkOutput($sformatf("fixGrantValid%0d", c), fixBus.grant_valid, (win >= 0));
      checkOutput($sformatf("fixGrantIndex%0d", c), fixBus.grant_index, (win >= 0) ? win : 0);
      checkOutput($sformatf("fixOreq%0d", c), fixBus.oreq, (win >= 0) ? fixReq[win] : '0);
      for (int i = 0; i < N; i++) begin
        expResp = (i == win) ? resp : '0;
        checkOutput($sformatf("fixIresps%0d_%0d", c, i), fixBus.iresps[i], expResp);
      end
    end

    // Single input: pass-through with the grant held across a 2-beat burst, even
    // when the master drops valid before the last beat.
    oneReq       = '0;
    oneReq.len   = 4'd1;
    oneReq.addr  = 32'h0000_BEE0;
    oneReq.wdata = 32'h1234_5678;
    for (int c = 0; c < 6; c++) begin
      applyStimulus();
      oneReq.valid     = oneValid[c];
      oneBus.ireqs[0]  = oneReq;
      resp             = '0;
      resp.ready       = oneReady[c];
      resp.last        = oneLast[c];
      resp.rdata       = 32'h5500_0000 + 32'(c);
      oneBus.oresp     = resp;
      @(negedge clk);
      checkOutput($sformatf("oneGrantValid%0d", c), oneBus.grant_valid, oneGrant[c]);
      checkOutput($sformatf("oneGrantIndex%0d", c), oneBus.grant_index, 0);
      checkOutput($sformatf("oneOreq%0d", c), oneBus.oreq, oneGrant[c] ? oneReq : '0);
      checkOutput($sformatf("oneIresps%0d", c), oneBus.iresps[0], oneGrant[c] ? resp : '0);
    end

    applyStimulus();
    oneBus.ireqs[0] = '0;
    oneBus.oresp    = '0;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
